// File: rtl/branch_seq_ctrl.sv
// Branch/jump sequencing controller for the multi-cycle datapath.
// Moore FSM steering ALU, PC-write and link enables per request.
module branch_seq_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       br_type,
    input  logic             gt,
    input  logic             eq,
    output logic [1:0]       alu_op,
    output logic [1:0]       branch_ctrl,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic [1:0]       pc_src,
    output logic             link_write,
    output logic             busy,
    output logic             done,
    output logic             taken,
    output logic             err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] nottaken_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        TARGET,
        COMPARE,
        RESOLVE,
        LINK,
        JUMP,
        DONE
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] br_q;
    logic       gt_q;
    logic       eq_q;
    logic       taken_q;
    logic       err_q;
    logic       cond;
    logic       req;
    logic       illegal;

    assign req     = (state_q == IDLE) && start;
    assign illegal = (br_type == 3'b111);

    always_comb begin
        cond = 1'b0;
        case (br_q[1:0])
            2'b00:   cond = eq_q;
            2'b01:   cond = ~eq_q;
            2'b10:   cond = gt_q;
            default: cond = ~gt_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    unique case (1'b1)
                        (br_type[2] == 1'b0):  state_d = TARGET;
                        (br_type == 3'b101):   state_d = LINK;
                        (br_type == 3'b100),
                        (br_type == 3'b110):   state_d = JUMP;
                        illegal:               state_d = IDLE;
                    endcase
                end
            end
            TARGET:  state_d = COMPARE;
            COMPARE: state_d = RESOLVE;
            RESOLVE: state_d = DONE;
            LINK:    state_d = JUMP;
            JUMP:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        alu_op      = 2'b00;
        branch_ctrl = 2'b00;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        pc_src      = 2'b00;
        link_write  = 1'b0;
        busy        = (state_q != IDLE);
        done        = 1'b0;
        taken       = taken_q;
        err         = err_q;
        case (state_q)
            TARGET:  alu_op = 2'b01;
            COMPARE: alu_op = 2'b10;
            RESOLVE: begin
                PCWriteCond = 1'b1;
                taken       = cond;
                // Mux select order is gt, ~gt, ~eq, eq.
                case (br_q[1:0])
                    2'b00:   branch_ctrl = 2'b11;
                    2'b01:   branch_ctrl = 2'b10;
                    2'b10:   branch_ctrl = 2'b00;
                    default: branch_ctrl = 2'b01;
                endcase
            end
            LINK:    link_write = 1'b1;
            JUMP: begin
                PCWrite = 1'b1;
                taken   = 1'b1;
                pc_src  = (br_q == 3'b110) ? 2'b10 : 2'b01;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            br_q         <= 3'b000;
            gt_q         <= 1'b0;
            eq_q         <= 1'b0;
            taken_q      <= 1'b0;
            err_q        <= 1'b0;
            taken_cnt    <= '0;
            nottaken_cnt <= '0;
        end else begin
            state_q <= state_d;
            err_q   <= req && illegal;
            if (req) begin
                br_q <= br_type;
            end
            // An illegal request leaves the previous outcome visible.
            if (req && !illegal) begin
                taken_q <= 1'b0;
            end
            if (state_q == COMPARE) begin
                gt_q <= gt;
                eq_q <= eq;
            end
            if (state_q == RESOLVE) begin
                taken_q <= cond;
                if (cond && !(&taken_cnt)) begin
                    taken_cnt <= taken_cnt + CNT_W'(1);
                end
                if (!cond && !(&nottaken_cnt)) begin
                    nottaken_cnt <= nottaken_cnt + CNT_W'(1);
                end
            end
            if (state_q == JUMP) begin
                taken_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Directed bench for branch_seq_ctrl: per-cycle vector table
// plus hand sequences for busy-start, mid-op reset and saturation.
module tb_branch_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] br_type;
    logic       gt;
    logic       eq;
    logic [1:0] alu_op;
    logic [1:0] branch_ctrl;
    logic       PCWrite;
    logic       PCWriteCond;
    logic [1:0] pc_src;
    logic       link_write;
    logic       busy;
    logic       done;
    logic       taken;
    logic       err;
    logic [3:0] taken_cnt;
    logic [3:0] nottaken_cnt;

    branch_seq_ctrl #(.CNT_W(4)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .br_type(br_type),
        .gt(gt),
        .eq(eq),
        .alu_op(alu_op),
        .branch_ctrl(branch_ctrl),
        .PCWrite(PCWrite),
        .PCWriteCond(PCWriteCond),
        .pc_src(pc_src),
        .link_write(link_write),
        .busy(busy),
        .done(done),
        .taken(taken),
        .err(err),
        .taken_cnt(taken_cnt),
        .nottaken_cnt(nottaken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] alu;
        logic [1:0] bc;
        logic       pcw;
        logic       pcwc;
        logic [1:0] src;
        logic       link;
        logic       busy;
        logic       done;
        logic       tk;
        logic       err;
    } obs_t;

    // inc: 0 none, 1 taken counter, 2 not-taken counter
    typedef struct {
        logic [2:0] bt;
        logic       gt;
        logic       eq;
        int         lat;
        logic [1:0] bc;
        logic [1:0] src;
        logic       tk;
        int         inc;
    } vec_t;

    obs_t obs;
    assign obs = {alu_op, branch_ctrl, PCWrite, PCWriteCond, pc_src,
                  link_write, busy, done, taken, err};

    vec_t tbl[12];
    int   n_vec = 0;
    int   n_bad = 0;
    int   exp_tc = 0;
    int   exp_nc = 0;

    task automatic chk_obs(input string nm, input obs_t want);
        n_vec++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, obs, want);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    // Stage codes: 1 T, 2 C, 3 R, 4 L, 5 J, 6 D, 7 illegal
    function automatic obs_t expect_at(input vec_t v, input int c);
        obs_t e;
        int   s;
        e = '0;
        s = 0;
        if (v.bt == 3'b111) begin
            s = (c == 1) ? 7 : 0;
        end else if (v.bt[2] == 1'b0) begin
            case (c)
                1: s = 1;
                2: s = 2;
                3: s = 3;
                4: s = 6;
                default: s = 0;
            endcase
        end else if (v.bt == 3'b101) begin
            case (c)
                1: s = 4;
                2: s = 5;
                3: s = 6;
                default: s = 0;
            endcase
        end else begin
            case (c)
                1: s = 5;
                2: s = 6;
                default: s = 0;
            endcase
        end
        e.busy = (s >= 1 && s <= 6);
        case (s)
            1: e.alu = 2'b01;
            2: e.alu = 2'b10;
            3: begin
                e.pcwc = 1'b1;
                e.bc   = v.bc;
                e.tk   = v.tk;
            end
            4: e.link = 1'b1;
            5: begin
                e.pcw = 1'b1;
                e.src = v.src;
                e.tk  = 1'b1;
            end
            6: begin
                e.done = 1'b1;
                e.tk   = v.tk;
            end
            7: begin
                e.err = 1'b1;
                e.tk  = v.tk;
            end
            default: ;
        endcase
        return e;
    endfunction

    task automatic run_req(input vec_t v, input string nm);
        obs_t idle_e;
        start   = 1'b1;
        br_type = v.bt;
        gt      = v.gt;
        eq      = v.eq;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= v.lat; c++) begin
            chk_obs($sformatf("%s c%0d", nm, c), expect_at(v, c));
            @(posedge clk);
            #1;
        end
        if (v.inc == 1 && exp_tc < 15) exp_tc++;
        if (v.inc == 2 && exp_nc < 15) exp_nc++;
        idle_e    = '0;
        idle_e.tk = v.tk;
        chk_obs({nm, " idle"}, idle_e);
        chk_int({nm, " tcnt"}, int'(taken_cnt), exp_tc);
        chk_int({nm, " ncnt"}, int'(nottaken_cnt), exp_nc);
    endtask

    initial begin
        int n_done;
        int n_pcw;
        int n_pcwc;

        tbl[0]  = '{3'b000, 1'b0, 1'b1, 4, 2'b11, 2'b00, 1'b1, 1};
        tbl[1]  = '{3'b000, 1'b1, 1'b0, 4, 2'b11, 2'b00, 1'b0, 2};
        tbl[2]  = '{3'b001, 1'b0, 1'b0, 4, 2'b10, 2'b00, 1'b1, 1};
        tbl[3]  = '{3'b001, 1'b0, 1'b1, 4, 2'b10, 2'b00, 1'b0, 2};
        tbl[4]  = '{3'b010, 1'b1, 1'b0, 4, 2'b00, 2'b00, 1'b1, 1};
        tbl[5]  = '{3'b010, 1'b0, 1'b1, 4, 2'b00, 2'b00, 1'b0, 2};
        tbl[6]  = '{3'b011, 1'b0, 1'b0, 4, 2'b01, 2'b00, 1'b1, 1};
        tbl[7]  = '{3'b011, 1'b1, 1'b0, 4, 2'b01, 2'b00, 1'b0, 2};
        tbl[8]  = '{3'b100, 1'b0, 1'b0, 2, 2'b00, 2'b01, 1'b1, 0};
        tbl[9]  = '{3'b101, 1'b0, 1'b0, 3, 2'b00, 2'b01, 1'b1, 0};
        tbl[10] = '{3'b110, 1'b0, 1'b0, 2, 2'b00, 2'b10, 1'b1, 0};
        tbl[11] = '{3'b111, 1'b0, 1'b0, 1, 2'b00, 2'b00, 1'b1, 0};

        reset   = 1'b0;
        start   = 1'b0;
        br_type = 3'b000;
        gt      = 1'b0;
        eq      = 1'b0;
        #12;
        chk_obs("reset outs", '0);
        chk_int("reset tcnt", int'(taken_cnt), 0);
        chk_int("reset ncnt", int'(nottaken_cnt), 0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            run_req(tbl[i], $sformatf("vec%0d", i));
        end

        // start raised during COMPARE of a BNE must be dropped
        start   = 1'b1;
        br_type = 3'b001;
        gt      = 1'b0;
        eq      = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start   = 1'b1;
        br_type = 3'b100;
        @(posedge clk);
        #1;
        start  = 1'b0;
        n_done = 0;
        n_pcw  = 0;
        for (int c = 0; c < 8; c++) begin
            n_done += int'(done);
            n_pcw  += int'(PCWrite);
            @(posedge clk);
            #1;
        end
        exp_tc++;
        chk_int("busy start dones", n_done, 1);
        chk_int("busy start pcw", n_pcw, 0);
        chk_int("busy start tcnt", int'(taken_cnt), exp_tc);
        chk_int("busy start busy", int'(busy), 0);

        // reset dropped while a BEQ sits in COMPARE
        start   = 1'b1;
        br_type = 3'b000;
        eq      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk_int("pre-rst alu", int'(alu_op), 2);
        #2;
        reset = 1'b0;
        #1;
        exp_tc = 0;
        exp_nc = 0;
        chk_obs("mid rst outs", '0);
        chk_int("mid rst tcnt", int'(taken_cnt), 0);
        chk_int("mid rst ncnt", int'(nottaken_cnt), 0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        n_pcwc = 0;
        for (int c = 0; c < 6; c++) begin
            n_pcwc += int'(PCWriteCond);
            @(posedge clk);
            #1;
        end
        chk_int("post rst pcwc", n_pcwc, 0);
        run_req(tbl[8], "post rst J");

        for (int i = 0; i < 17; i++) begin
            run_req(tbl[0], $sformatf("sat%0d", i));
        end
        chk_int("sat tcnt", int'(taken_cnt), 15);
        chk_int("sat ncnt", int'(nottaken_cnt), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/branch_seq_ctrl.md
BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of taken/not-taken statistics counters.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL have port start  input  1  one-cycle request from main control; sampled only in IDLE.
REQ-005 SHALL have port br_type  input  3  000 BEQ, 001 BNE, 010 BGT, 011 BLE, 100 J, 101 JAL, 110 JR, 111 illegal.
REQ-006 SHALL have ports gt, eq  input  1 each  ALU compare flags, valid in COMPARE cycle.
REQ-007 SHALL have port alu_op  output  2  00 idle, 01 add (PC+offset), 10 subtract (A-B).
REQ-008 SHALL have port branch_ctrl  output  2  condition select to PC-write mux: 00 gt, 01 ~gt, 10 ~eq, 11 eq.
REQ-009 SHALL have ports PCWrite, PCWriteCond  output  1 each  unconditional / conditional PC write enables.
REQ-010 SHALL have port pc_src  output  2  00 ALUOut (branch target), 01 jump field, 10 register A (JR).
REQ-011 SHALL have port link_write  output  1  writes PC into $ra (JAL).
REQ-012 SHALL have ports busy, done, taken, err  output  1 each  status; done/err are one-cycle pulses.
REQ-013 SHALL have ports taken_cnt, nottaken_cnt  output  CNT_W each  conditional-branch statistics.

Function
REQ-014 SHALL implement a Moore FSM with states IDLE, TARGET, COMPARE, RESOLVE, LINK, JUMP, DONE; all control outputs decoded from state and latched br_type only.
REQ-015 SHALL in IDLE with start=1 latch br_type; next state TARGET for 000-011, LINK for 101, JUMP for 100/110; 111 -> pulse err for one cycle, remain IDLE, no PC write.
REQ-016 SHALL in TARGET drive alu_op=01; next COMPARE.
REQ-017 SHALL in COMPARE drive alu_op=10 and register gt, eq at end of cycle; next RESOLVE.
REQ-018 SHALL in RESOLVE drive PCWriteCond=1, pc_src=00, branch_ctrl = {00 BGT, 01 BLE, 10 BNE, 11 BEQ}; next DONE.
REQ-019 SHALL compute taken in RESOLVE from registered flags with the same mapping (BGT gt, BLE ~gt, BNE ~eq, BEQ eq) and hold it until next start is accepted.
REQ-020 SHALL in RESOLVE increment taken_cnt if taken else nottaken_cnt; each counter saturates at all-ones, never wraps.
REQ-021 SHALL in LINK assert link_write=1 for one cycle; next JUMP.
REQ-022 SHALL in JUMP assert PCWrite=1, pc_src=01 (J/JAL) or 10 (JR), taken=1; counters unchanged; next DONE.
REQ-023 SHALL in DONE pulse done=1; next IDLE; start in DONE is ignored (no queuing).
REQ-024 SHALL hold busy=1 in every state except IDLE; start while busy is ignored.
REQ-025 SHALL make PCWrite and PCWriteCond mutually exclusive and each at most one cycle per request.
REQ-026 SHALL give latency start->done of 4 cycles (branch), 3 cycles (JAL), 2 cycles (J/JR).
REQ-027 SHALL drive alu_op=00, branch_ctrl=00, pc_src=00 in states not listed above as driving them.

Reset
REQ-028 SHALL on reset=0, regardless of clk, force IDLE, all 1-bit outputs 0, alu_op/branch_ctrl/pc_src=00, taken_cnt=nottaken_cnt=0, latched flags and br_type=0.
REQ-029 SHALL on reset mid-operation abandon the request with no further PC write, link write or counter update; after release the FSM accepts start from IDLE the next edge.

Verification
REQ-030 SHALL cover: BEQ with eq=1 in COMPARE -> RESOLVE shows PCWriteCond=1, branch_ctrl=11, taken=1, taken_cnt 0->1, done 4 cycles after start.
REQ-031 SHALL cover: BGT with gt=0 -> branch_ctrl=00, taken=0, nottaken_cnt 0->1, PCWrite stays 0 throughout.
REQ-032 SHALL cover: JAL -> link_write=1 at cycle 1, PCWrite=1 with pc_src=01 at cycle 2, done at cycle 3; JR -> pc_src=10, done at cycle 2.
REQ-033 SHALL cover: br_type=111 -> err pulse one cycle, busy=0, no enables asserted; start asserted during COMPARE of a BNE -> ignored, exactly one done.
REQ-034 SHALL cover: reset=0 asserted in COMPARE -> immediate IDLE, all outputs 0, counters 0, no PCWriteCond pulse afterwards.
REQ-035 SHALL cover: CNT_W=4, 17 taken BEQs -> taken_cnt saturates at 15, nottaken_cnt stays 0.
